// File: rtl/audio_i2s_tx.sv
// ---------------------------------------------------------------------------
// audio_i2s_tx
//   I2S transmitter for the codec audio path. Accepts one 16-bit stereo pair
//   at a time over a valid/ready handshake into a single-entry buffer and
//   serialises it as 64-BCLK frames: two 32-bit slots, MSB first, with data
//   delayed one BCLK after the WCLK transition. The block is held in its reset
//   state until the codec configuration sequencer raises iCFG_DONE.
//
// Parameters
//   CLK_DIV   iCLK_50 cycles per BCLK half-period (2..255)
//   SAMPLE_W  sample width, fixed at 16
//
// Ports
//   iCLK_50       system clock
//   iRESET        asynchronous active-high reset
//   iCFG_DONE     codec configured (level, iCLK_50 domain); low = idle
//   iLEFT/iRIGHT  sample pair, two's complement
//   iVALID        sample pair valid
//   oREADY        buffer empty and running, pair can be accepted
//   oBCLK         I2S bit clock
//   oWCLK         I2S word clock (0 = left slot)
//   oDOUT         I2S serial data, changes on BCLK falling edges
//   oSAMPLE_TICK  one-cycle pulse at every frame load
//   oUNDERRUN     one-cycle pulse when a frame loads from an empty buffer
// ---------------------------------------------------------------------------
module audio_i2s_tx #(
  parameter int CLK_DIV  = 8,
  parameter int SAMPLE_W = 16
) (
  input  logic                iCLK_50,
  input  logic                iRESET,
  input  logic                iCFG_DONE,
  input  logic [SAMPLE_W-1:0] iLEFT,
  input  logic [SAMPLE_W-1:0] iRIGHT,
  input  logic                iVALID,
  output logic                oREADY,
  output logic                oBCLK,
  output logic                oWCLK,
  output logic                oDOUT,
  output logic                oSAMPLE_TICK,
  output logic                oUNDERRUN
);

  localparam int DIV_W  = 8;
  localparam int SLOT_W = 32;
  localparam int PAD_W  = SLOT_W - SAMPLE_W;

  logic [DIV_W-1:0]    r_div;
  logic [5:0]          r_bidx;
  logic                r_full;
  logic [SAMPLE_W-1:0] r_buf_l;
  logic [SAMPLE_W-1:0] r_buf_r;
  logic [63:0]         r_shift;

  logic        w_tc;
  logic        w_fall;
  logic [5:0]  w_bnext;
  logic        w_load;
  logic        w_xfer;
  logic        w_full_next;
  logic [63:0] w_word;

  assign w_tc    = (r_div == DIV_W'(CLK_DIV - 1));
  // A terminal count while BCLK is high is the falling edge.
  assign w_fall  = w_tc && oBCLK;
  assign w_bnext = r_bidx + 6'd1;
  assign w_load  = w_fall && (r_bidx == 6'd63);
  assign w_xfer  = iVALID && oREADY;

  // On a load edge the new word's MSB goes straight to oDOUT, so the word
  // feeding the output/shift path is selected here rather than in r_shift.
  always_comb begin
    w_word = r_shift;
    if (w_load) begin
      if (r_full)
        w_word = {r_buf_l, {PAD_W{1'b0}}, r_buf_r, {PAD_W{1'b0}}};
      else
        w_word = 64'h0;
    end
  end

  // Load empties the buffer, but a pair accepted on that same cycle refills
  // it for the following frame. A transfer can only happen while empty.
  assign w_full_next = w_load ? w_xfer : (r_full | w_xfer);

  always_ff @(posedge iCLK_50 or posedge iRESET) begin
    if (iRESET) begin
      r_div        <= '0;
      r_bidx       <= 6'd63;
      r_full       <= 1'b0;
      r_buf_l      <= '0;
      r_buf_r      <= '0;
      r_shift      <= '0;
      oREADY       <= 1'b0;
      oBCLK        <= 1'b0;
      oWCLK        <= 1'b0;
      oDOUT        <= 1'b0;
      oSAMPLE_TICK <= 1'b0;
      oUNDERRUN    <= 1'b0;
    end else if (!iCFG_DONE) begin
      // Idle: everything parked at reset values, buffered pair discarded.
      r_div        <= '0;
      r_bidx       <= 6'd63;
      r_full       <= 1'b0;
      r_buf_l      <= '0;
      r_buf_r      <= '0;
      r_shift      <= '0;
      oREADY       <= 1'b0;
      oBCLK        <= 1'b0;
      oWCLK        <= 1'b0;
      oDOUT        <= 1'b0;
      oSAMPLE_TICK <= 1'b0;
      oUNDERRUN    <= 1'b0;
    end else begin
      oSAMPLE_TICK <= 1'b0;
      oUNDERRUN    <= 1'b0;

      if (w_tc) begin
        r_div <= '0;
        oBCLK <= ~oBCLK;
      end else begin
        r_div <= r_div + DIV_W'(1);
      end

      if (w_fall) begin
        r_bidx  <= w_bnext;
        // WCLK leads each slot by one BCLK: right slot data is b=32..63.
        oWCLK   <= (w_bnext >= 6'd31) && (w_bnext <= 6'd62);
        oDOUT   <= w_word[63];
        r_shift <= {w_word[62:0], 1'b0};
      end

      if (w_load) begin
        oSAMPLE_TICK <= 1'b1;
        oUNDERRUN    <= ~r_full;
      end

      if (w_xfer) begin
        r_buf_l <= iLEFT;
        r_buf_r <= iRIGHT;
      end

      r_full <= w_full_next;
      oREADY <= ~w_full_next;
    end
  end

endmodule

// File: doc/audio_i2s_tx.md
Name: audio_i2s_tx

Overview:
- I2S transmitter for the DECA audio codec path, directly downstream of the SPI codec-configuration sequencer.
- Accepts 16-bit stereo samples over a valid/ready handshake, holds one sample pair in a buffer, and serialises it as 64-BCLK I2S frames (two 32-bit slots, MSB first, one-bit delay).
- Stays silent and idle until the configuration sequencer reports that codec setup is complete.

Parameters:
- CLK_DIV, 8: iCLK_50 cycles per BCLK half-period (range 2..255). Default gives 3.125 MHz BCLK and about 48.8 kHz fs.
- SAMPLE_W, 16: sample width. Fixed at 16, not otherwise supported.

Ports:
- iCLK_50  in  1  system clock, 50 MHz.
- iRESET  in  1  asynchronous, active-high reset.
- iCFG_DONE  in  1  codec configured; level, synchronous to iCLK_50.
- iLEFT  in  16  left sample, two's complement.
- iRIGHT  in  16  right sample.
- iVALID  in  1  sample pair valid.
- oREADY  out  1  sample buffer empty, can accept.
- oBCLK  out  1  I2S bit clock.
- oWCLK  out  1  I2S word clock (0 = left).
- oDOUT  out  1  I2S serial data.
- oSAMPLE_TICK  out  1  one-cycle pulse at each frame load.
- oUNDERRUN  out  1  one-cycle pulse when a frame loads from an empty buffer.

Behaviour:
- Reset (async, iRESET=1):
  - oBCLK=0, oWCLK=0, oDOUT=0, oREADY=0, oSAMPLE_TICK=0, oUNDERRUN=0.
  - Divider counter=0, bit index b=63, buffer empty, shift register=0.
- All outputs are registered.
- IDLE state (iCFG_DONE=0):
  - Every register held at its reset value. oREADY=0, so no samples are accepted.
  - If iCFG_DONE falls mid-frame, the block enters IDLE on the next clock. The buffer is discarded and no pulses are emitted.
- RUN state (iCFG_DONE=1):
  - Divider counts 0..CLK_DIV-1. At terminal count it wraps to 0 and oBCLK toggles.
  - The first toggle after entering RUN is rising. The first falling edge occurs 2*CLK_DIV cycles after iCFG_DONE is sampled high.
- On every BCLK falling edge (the same cycle oBCLK is registered low):
  - b advances modulo 64.
  - oWCLK is set to 1 when the new b is in 31..62, otherwise 0.
  - oDOUT is set to shift[63], and the shift register then shifts left with 0 fill.
- Frame load, on the falling edge where b goes from 63 to 0:
  - Buffer full: shift <= {L,16'h0,R,16'h0}, buffer becomes empty, oSAMPLE_TICK pulses.
  - Buffer empty: shift <= 0, oSAMPLE_TICK pulses and oUNDERRUN pulses.
  - oDOUT on that same edge is the MSB of the newly loaded word (L[15] or 0).
- Resulting bit mapping: left bits 15..0 appear at b=0..15, right bits 15..0 at b=32..47, zeros elsewhere. oWCLK leads each slot by one BCLK.
- Handshake:
  - oREADY = RUN and buffer empty.
  - A transfer occurs on a clock where iVALID and oREADY are both 1. iLEFT/iRIGHT are captured and the buffer becomes full, so oREADY drops on the next cycle.
  - iVALID with oREADY=0 has no effect. The source must hold its data.
- Simultaneous transfer and frame load on an empty buffer: the frame loads zeros (underrun), and the incoming pair is captured into the buffer for the next frame.
- Full buffer is never overwritten. The buffer empties only at frame load.
- Samples are never dropped or duplicated. Underrun frames are pure silence.

Test Plan:
- Reset, then hold iCFG_DONE=0 for 1000 cycles -> all outputs stay 0 and oREADY stays 0 throughout.
- CLK_DIV=2, iCFG_DONE=1, offer L=16'hA5C3, R=16'h0F81 before the first frame -> first frame DOUT at b=0..15 is A5C3 MSB first; at b=32..47 it is 0F81; other bits 0; WCLK high exactly at b=31..62; oSAMPLE_TICK pulses once per 256 cycles.
- No samples supplied -> oUNDERRUN pulses every frame (every 256 cycles at CLK_DIV=2) and oDOUT stays 0.
- iVALID held high with an incrementing L=R=n -> one sample accepted per frame, in order, with none lost or repeated; oREADY high only between a frame load and the next accept.
- Transfer asserted on the exact frame-load cycle with an empty buffer -> that frame is zeros with an oUNDERRUN pulse; the next frame carries the sample.
- Drop iCFG_DONE at b=20, then raise it again -> outputs go to 0 the next cycle and the buffer is cleared; restart has the first falling edge 2*CLK_DIV cycles later with b=0; assert iRESET mid-frame -> immediate asynchronous return to reset values.
